// File: rtl/hall_conditioner_if.sv
// rtl/hall_conditioner_if.sv - hall channel signal bundle between control logic and the conditioner
interface hall_conditioner_if #(
    parameter int PERIOD_W = 20
);
    logic                hallRaw;
    logic                enable;
    logic                hallClean;
    logic                hallPulse;
    logic [PERIOD_W-1:0] period;
    logic                periodValid;
    logic                stall;

    modport master (
        output hallRaw,
        output enable,
        input  hallClean,
        input  hallPulse,
        input  period,
        input  periodValid,
        input  stall
    );

    modport slave (
        input  hallRaw,
        input  enable,
        output hallClean,
        output hallPulse,
        output period,
        output periodValid,
        output stall
    );
endinterface

// File: rtl/hall_conditioner.sv
// rtl/hall_conditioner.sv - hall input synchronizer, debouncer, edge pulse, period and stall measurement
module hall_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500,
    parameter int PERIOD_W        = 20,
    parameter int STALL_CYCLES    = 1000000
) (
    input  logic            CLK,
    input  logic            RESET,
    hall_conditioner_if.slave hall
);
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0]     DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PERIOD_W-1:0] STALL_LAST = PERIOD_W'(STALL_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        MEASURE,
        STALLED
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [DB_W-1:0]        db_cnt;
    logic                   clean_q;
    logic                   clean_d;
    logic                   pulse_q;

    state_t                 state_q, state_d;
    logic [PERIOD_W-1:0]    cnt_q, cnt_d;
    logic [PERIOD_W-1:0]    period_q, period_d;
    logic                   valid_q, valid_d;
    logic                   stall_q, stall_d;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], hall.hallRaw};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Any return to the current clean level restarts the stability count.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            db_cnt  <= '0;
            clean_q <= 1'b0;
        end else if (sync != clean_q) begin
            if (db_cnt == DB_LAST) begin
                clean_q <= sync;
                db_cnt  <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end else begin
            db_cnt <= '0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            clean_d <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            clean_d <= clean_q;
            pulse_q <= hall.enable & clean_q & ~clean_d;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            stall_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            stall_q  <= stall_d;
        end
    end

    // A pulse takes priority over the stall threshold, so a pulse landing exactly
    // on the last counted cycle still records a period of STALL_CYCLES.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        valid_d  = 1'b0;
        stall_d  = stall_q;
        if (!hall.enable) begin
            state_d  = IDLE;
            cnt_d    = '0;
            period_d = '0;
            stall_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = ARMED;
                    cnt_d    = '0;
                    period_d = '0;
                    stall_d  = 1'b0;
                end
                ARMED: begin
                    if (pulse_q) begin
                        state_d = MEASURE;
                        cnt_d   = '0;
                    end else if (cnt_q == STALL_LAST) begin
                        state_d = STALLED;
                        stall_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                MEASURE: begin
                    if (pulse_q) begin
                        period_d = cnt_q + 1'b1;
                        valid_d  = 1'b1;
                        cnt_d    = '0;
                    end else if (cnt_q == STALL_LAST) begin
                        state_d = STALLED;
                        stall_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STALLED: begin
                    stall_d = 1'b1;
                    if (pulse_q) begin
                        state_d = MEASURE;
                        stall_d = 1'b0;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign hall.hallClean   = clean_q;
    assign hall.hallPulse   = pulse_q;
    assign hall.period      = period_q;
    assign hall.periodValid = valid_q;
    assign hall.stall       = stall_q;
endmodule
